// File: rtl/tmp_pkg.sv
// Shared definitions for the temperature sample path: FSM states and range limits.
// calcu_tmp reuses the sensor range constants so both ends agree on what is plausible.
package tmp_pkg;

    localparam int         DATA_W_DEF   = 8;
    localparam logic [7:0] SENSOR_MIN_C = 8'd0;
    localparam logic [7:0] SENSOR_MAX_C = 8'd125;
    localparam logic [7:0] MAX_VALID_DEF = SENSOR_MAX_C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCUM  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/tmp_avg_ring.sv
// Ring buffer with running sum for a power-of-two moving average.
// A push always wins over a flush arriving in the same cycle.
module tmp_avg_ring #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         flush,
    output logic [DATA_W+DEPTH_LOG2-1:0] sum,
    output logic                         full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = DATA_W + DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   fill;
    logic [DATA_W-1:0]     oldest;

    assign full   = (fill == (DEPTH_LOG2+1)'(DEPTH));
    // Until the window is full the slot being overwritten has never been summed.
    assign oldest = full ? mem[wr_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= wr_ptr + 1'b1;
            if (!full) begin
                fill <= fill + 1'b1;
            end
            sum <= sum + SUM_W'(data_in) - SUM_W'(oldest);
        end else if (flush) begin
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end
    end

endmodule

// File: rtl/tmp_sample_filter.sv
// Captures raw I2C temperature reads, rejects implausible values, averages
// accepted samples and flags the output stale when the sensor goes quiet.
module tmp_sample_filter
    import tmp_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                DEPTH_LOG2  = 3,
    parameter logic [DATA_W-1:0] MAX_VALID   = DATA_W'(MAX_VALID_DEF),
    parameter int                TIMEOUT_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_done,
    input  logic [DATA_W-1:0] i2c_r_data,
    output logic [DATA_W-1:0] tmp_out,
    output logic              tmp_valid,
    output logic              tmp_update,
    output logic              stale,
    output logic [7:0]        reject_cnt,
    output state_t            fsm_state
);

    localparam int SUM_W = DATA_W + DEPTH_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic              done_q;
    logic              start;
    logic [DATA_W-1:0] raw_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              push;
    logic              flush;
    logic              full;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W:0]    rounded;

    assign start     = i2c_done & ~done_q;
    assign push      = (state == ACCUM);
    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign flush     = tmo_hit & ~push;
    assign rounded   = {1'b0, sum} + (SUM_W+1)'(1 << (DEPTH_LOG2 - 1));
    assign fsm_state = state;

    tmp_avg_ring #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .data_in (raw_q),
        .flush   (flush),
        .sum     (sum),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // Loading done_q here stops a level held across reset release from looking like a new edge.
            done_q     <= i2c_done;
            state      <= IDLE;
            raw_q      <= '0;
            tmp_out    <= '0;
            tmp_valid  <= 1'b0;
            tmp_update <= 1'b0;
            stale      <= 1'b0;
            reject_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            done_q     <= i2c_done;
            tmp_update <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        raw_q <= i2c_r_data;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (raw_q[DATA_W-1] || (raw_q > MAX_VALID)) begin
                        if (reject_cnt != 8'hFF) begin
                            reject_cnt <= reject_cnt + 8'd1;
                        end
                        state <= IDLE;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    tmp_out    <= full ? rounded[DEPTH_LOG2 +: DATA_W] : raw_q;
                    tmp_update <= 1'b1;
                    tmp_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // The counter parks at TIMEOUT_CYC until the next accepted sample.
            if (push) begin
                tmo_cnt <= '0;
                stale   <= 1'b0;
            end else if (tmo_cnt < CNT_W'(TIMEOUT_CYC)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_hit) begin
                    stale     <= 1'b1;
                    tmp_valid <= 1'b0;
                end
            end
        end
    end

endmodule
